// File: rtl/actor_move_engine.sv
// Per-frame grid movement engine: steps NUM_ACTORS actors one tile per tick using a shared wall-lookup port.
// Optional ACTOR_COLLIDE_EN adds a registered collide vector (actors landing on actor 0's tile).
module actor_move_engine #(
    parameter int NUM_ACTORS = 4,
    parameter int POS_W      = 5,
    parameter int POS_MIN    = 1,
    parameter int POS_MAX    = 27,
    localparam int IDX_W     = (NUM_ACTORS > 1) ? $clog2(NUM_ACTORS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [2*NUM_ACTORS-1:0]   want_dir,
    input  logic                      load,
    input  logic [IDX_W-1:0]          load_idx,
    input  logic [POS_W-1:0]          load_x,
    input  logic [POS_W-1:0]          load_y,
    input  logic [1:0]                load_dir,
    output logic                      map_req,
    output logic [POS_W-1:0]          map_x,
    output logic [POS_W-1:0]          map_y,
    input  logic                      map_ack,
    input  logic                      map_wall,
    output logic [POS_W*NUM_ACTORS-1:0] pos_x,
    output logic [POS_W*NUM_ACTORS-1:0] pos_y,
    output logic [2*NUM_ACTORS-1:0]   cur_dir,
    output logic                      busy,
    output logic                      done
`ifdef ACTOR_COLLIDE_EN
    ,
    output logic [NUM_ACTORS-1:0]     collide
`endif
);

    typedef enum logic [2:0] {
        IDLE, TRY_WANT, WAIT_WANT, TRY_CUR, WAIT_CUR, NEXT, FINISH
    } state_t;

    localparam logic signed [POS_W:0] MIN_S = (POS_W+1)'(POS_MIN);
    localparam logic signed [POS_W:0] MAX_S = (POS_W+1)'(POS_MAX);
    localparam logic signed [POS_W:0] ONE_S = (POS_W+1)'(1);
    localparam logic [IDX_W-1:0]      LAST  = IDX_W'(NUM_ACTORS-1);

    state_t state, state_nxt;

    logic [POS_W-1:0] ax [NUM_ACTORS];
    logic [POS_W-1:0] ay [NUM_ACTORS];
    logic [1:0]       ad [NUM_ACTORS];
    logic [1:0]       wd [NUM_ACTORS];
    logic [IDX_W-1:0] idx;
    // Pending result for the current actor, committed only in NEXT
    logic [POS_W-1:0] nx, ny;
    logic [1:0]       nd;

    logic [1:0]              try_dir;
    logic signed [POS_W:0]   cx, cy;
    logic                    in_rng;
    logic                    same_dir;

    assign try_dir  = (state == TRY_CUR) ? ad[idx] : wd[idx];
    assign same_dir = (wd[idx] == ad[idx]);

    always_comb begin
        cx = signed'({1'b0, ax[idx]});
        cy = signed'({1'b0, ay[idx]});
        case (try_dir)
            2'd0: cy = cy - ONE_S;
            2'd1: cx = cx - ONE_S;
            2'd2: cy = cy + ONE_S;
            default: cx = cx + ONE_S;
        endcase
        in_rng = (cx >= MIN_S) && (cx <= MAX_S) && (cy >= MIN_S) && (cy <= MAX_S);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (tick) state_nxt = TRY_WANT;
            TRY_WANT:  state_nxt = in_rng ? WAIT_WANT : (same_dir ? NEXT : TRY_CUR);
            WAIT_WANT: if (map_ack)
                           state_nxt = (!map_wall || same_dir) ? NEXT : TRY_CUR;
            TRY_CUR:   state_nxt = in_rng ? WAIT_CUR : NEXT;
            WAIT_CUR:  if (map_ack) state_nxt = NEXT;
            NEXT:      state_nxt = (idx == LAST) ? FINISH : TRY_WANT;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign map_req = (state == WAIT_WANT) || (state == WAIT_CUR);
    assign busy    = (state != IDLE) && (state != FINISH);
    assign done    = (state == FINISH);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ACTORS; i++) begin
                ax[i] <= POS_W'(POS_MIN);
                ay[i] <= POS_W'(POS_MIN);
                ad[i] <= 2'd0;
                wd[i] <= 2'd0;
            end
            idx   <= '0;
            nx    <= '0;
            ny    <= '0;
            nd    <= 2'd0;
            map_x <= '0;
            map_y <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Load lands on the same edge as tick, so the pass sees loaded state
                    if (load && (int'(load_idx) < NUM_ACTORS)) begin
                        ax[load_idx] <= load_x;
                        ay[load_idx] <= load_y;
                        ad[load_idx] <= load_dir;
                    end
                    if (tick) begin
                        for (int i = 0; i < NUM_ACTORS; i++) wd[i] <= want_dir[2*i +: 2];
                        idx <= '0;
                    end
                end
                TRY_WANT, TRY_CUR: begin
                    if (state == TRY_WANT) begin
                        nx <= ax[idx];
                        ny <= ay[idx];
                        nd <= ad[idx];
                    end
                    if (in_rng) begin
                        map_x <= cx[POS_W-1:0];
                        map_y <= cy[POS_W-1:0];
                    end
                end
                WAIT_WANT: if (map_ack && !map_wall) begin
                    nx <= map_x;
                    ny <= map_y;
                    nd <= wd[idx];
                end
                WAIT_CUR: if (map_ack && !map_wall) begin
                    nx <= map_x;
                    ny <= map_y;
                end
                NEXT: begin
                    ax[idx] <= nx;
                    ay[idx] <= ny;
                    ad[idx] <= nd;
                    idx     <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_ACTORS; g++) begin : g_out
        assign pos_x[g*POS_W +: POS_W] = ax[g];
        assign pos_y[g*POS_W +: POS_W] = ay[g];
        assign cur_dir[2*g +: 2]       = ad[g];
    end

`ifdef ACTOR_COLLIDE_EN
    logic [NUM_ACTORS-1:0] coll_nxt;

    always_comb begin
        coll_nxt = '0;
        for (int i = 1; i < NUM_ACTORS; i++)
            coll_nxt[i] = (ax[i] == ax[0]) && (ay[i] == ay[0]);
        coll_nxt[0] = |coll_nxt[NUM_ACTORS-1:1];
    end

    always_ff @(posedge clk) begin
        if (reset)                collide <= '0;
        else if (state == FINISH) collide <= coll_nxt;
    end
`endif

endmodule

// File: tb/tb_actor_move_engine.sv
// Randomized bench for actor_move_engine against a tile-level movement model and a wall-map responder.
module tb_actor_move_engine;
    localparam int N  = 4;
    localparam int PW = 5;

    logic clk = 0, reset = 1, tick = 0, load = 0;
    logic [2*N-1:0]  want_dir = '0;
    logic [1:0]      load_idx = '0, load_dir = '0;
    logic [PW-1:0]   load_x = '0, load_y = '0;
    logic            map_req, map_ack = 0, map_wall = 0;
    logic [PW-1:0]   map_x, map_y;
    logic [PW*N-1:0] pos_x, pos_y;
    logic [2*N-1:0]  cur_dir;
    logic            busy, done;
`ifdef ACTOR_COLLIDE_EN
    logic [N-1:0]    collide;
`endif

    actor_move_engine dut (
        .clk(clk), .reset(reset), .tick(tick), .want_dir(want_dir),
        .load(load), .load_idx(load_idx), .load_x(load_x), .load_y(load_y), .load_dir(load_dir),
        .map_req(map_req), .map_x(map_x), .map_y(map_y), .map_ack(map_ack), .map_wall(map_wall),
        .pos_x(pos_x), .pos_y(pos_y), .cur_dir(cur_dir), .busy(busy), .done(done)
`ifdef ACTOR_COLLIDE_EN
        , .collide(collide)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int nreq = 0, nstart = 0, ndone = 0;
    int fixed_delay = -1, cnt = 0, cur_delay = 0;
    logic [PW-1:0] hx, hy;

    // Reference model: tile positions, directions, wall map, expected lookups
    int mx [N], my [N], md [N];
    bit wall [0:31][0:31];
    int exp_req;
    logic [N-1:0] m_coll = '0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int px(input int i); return int'(pos_x[i*PW +: PW]); endfunction
    function automatic int py(input int i); return int'(pos_y[i*PW +: PW]); endfunction
    function automatic int pd(input int i); return int'(cur_dir[2*i +: 2]); endfunction

    function automatic bit try_mv(input int i, input int d);
        int tx, ty;
        tx = mx[i] + ((d == 3) ? 1 : (d == 1) ? -1 : 0);
        ty = my[i] + ((d == 2) ? 1 : (d == 0) ? -1 : 0);
        if (tx < 1 || tx > 27 || ty < 1 || ty > 27) return 0;
        exp_req++;
        if (wall[tx][ty]) return 0;
        mx[i] = tx;
        my[i] = ty;
        return 1;
    endfunction

    task automatic model_pass(input logic [2*N-1:0] w);
        int wdv;
        exp_req = 0;
        for (int i = 0; i < N; i++) begin
            wdv = int'(w[2*i +: 2]);
            if (try_mv(i, wdv)) md[i] = wdv;
            else if (wdv != md[i]) void'(try_mv(i, md[i]));
        end
        m_coll = '0;
        for (int i = 1; i < N; i++) m_coll[i] = (mx[i] == mx[0]) && (my[i] == my[0]);
        m_coll[0] = |m_coll[N-1:1];
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin mx[i] = 1; my[i] = 1; md[i] = 0; end
        m_coll = '0;
    endtask

    task automatic clear_walls();
        for (int x = 0; x < 32; x++) for (int y = 0; y < 32; y++) wall[x][y] = 0;
    endtask

    task automatic check_state();
        for (int i = 0; i < N; i++) begin
            check($sformatf("pos_x%0d", i), px(i), mx[i]);
            check($sformatf("pos_y%0d", i), py(i), my[i]);
            check($sformatf("dir%0d", i), pd(i), md[i]);
        end
        check("busy_idle", busy, 0);
`ifdef ACTOR_COLLIDE_EN
        check("collide", collide, m_coll);
`endif
    endtask

    task automatic load_actor(input int i, input int x, input int y, input int d);
        load = 1; load_idx = 2'(i); load_x = PW'(x); load_y = PW'(y); load_dir = 2'(d);
        @(negedge clk);
        load = 0;
        mx[i] = x; my[i] = y; md[i] = d;
    endtask

    // Map responder: answers each lookup after a delay, checks coords hold while waiting
    initial forever begin
        @(negedge clk);
        if (done) ndone++;
        if (reset) begin
            map_ack = 0; cnt = 0;
        end else if (map_ack) begin
            map_ack = 0; cnt = 0;
        end else if (map_req) begin
            if (cnt == 0) begin
                hx = map_x; hy = map_y; nstart++;
                cur_delay = (fixed_delay < 0) ? int'($urandom_range(0, 3)) : fixed_delay;
            end else begin
                check("map_x_hold", map_x, hx);
                check("map_y_hold", map_y, hy);
            end
            if (cnt >= cur_delay) begin
                map_ack = 1; map_wall = wall[map_x][map_y]; nreq++;
            end else cnt++;
        end
    end

    task automatic run_pass(input logic [2*N-1:0] w, input bit mid_tick, input bit do_load,
                            input int li, input int lx, input int ly, input int ld);
        int r0, d0;
        bit got;
        if (do_load) begin
            load = 1; load_idx = 2'(li); load_x = PW'(lx); load_y = PW'(ly); load_dir = 2'(ld);
            mx[li] = lx; my[li] = ly; md[li] = ld;
        end
        model_pass(w);
        r0 = nreq; d0 = ndone;
        want_dir = w; tick = 1;
        @(negedge clk);
        tick = 0; load = 0; want_dir = 8'($urandom);
        got = 0;
        for (int cyc = 0; cyc < 2000 && !got; cyc++) begin
            if (done) got = 1;
            else begin
                if (mid_tick) tick = (cyc == 3);
                @(negedge clk);
            end
        end
        tick = 0;
        check("done_seen", got, 1);
        check("busy_at_done", busy, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("done_count", ndone - d0, 1);
        check("lookups", nreq - r0, exp_req);
        check_state();
    endtask

    initial begin
        int s0, d0, w;
        bit seen;
        clear_walls();
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_map_req", map_req, 0);
        check("rst_map_x", map_x, 0);
        check("rst_map_y", map_y, 0);
        check("rst_done", done, 0);
        reset = 0;
        @(negedge clk);
        check_state();

        // Simple move right into open space
        load_actor(0, 2, 2, 3);
        run_pass(8'h03, 0, 0, 0, 0, 0, 0);
        check("t1_x", px(0), 3);
        check("t1_y", py(0), 2);

        // Want blocked by wall, falls back to current direction
        load_actor(0, 2, 2, 3);
        wall[2][1] = 1;
        run_pass(8'h00, 0, 0, 0, 0, 0, 0);
        check("t2_x", px(0), 3);
        check("t2_dir", pd(0), 3);
        clear_walls();

        // Both tries off the map: no lookup at all
        load_actor(0, 1, 1, 0);
        run_pass(8'h01, 0, 0, 0, 0, 0, 0);
        check("t3_x", px(0), 1);
        check("t3_y", py(0), 1);

        // Slow map with a stray tick mid-pass
        fixed_delay = 5;
        load_actor(0, 2, 2, 3);
        run_pass(8'hC3, 1, 0, 0, 0, 0, 0);
        fixed_delay = -1;

        // Load and tick in the same cycle
        run_pass(8'h2E, 0, 1, 2, 27, 14, 3);

        // Reset during actor 2's want lookup
        for (int i = 0; i < N; i++) load_actor(i, 5 + 5*i, 5 + 5*i, 0);
        fixed_delay = 20;
        s0 = nstart; d0 = ndone;
        want_dir = 8'hFF; tick = 1;
        @(negedge clk);
        tick = 0;
        seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            if (nstart - s0 >= 3) seen = 1;
            else @(negedge clk);
        end
        check("t5_reached_actor2", seen, 1);
        reset = 1;
        @(negedge clk);
        model_reset();
        check("t5_map_req", map_req, 0);
        check("t5_busy", busy, 0);
        check("t5_map_x", map_x, 0);
        reset = 0;
        @(negedge clk);
        check("t5_no_done", ndone - d0, 0);
        check_state();
        fixed_delay = -1;

`ifdef ACTOR_COLLIDE_EN
        load_actor(0, 5, 5, 3);
        load_actor(1, 6, 5, 0);
        load_actor(2, 10, 10, 0);
        load_actor(3, 20, 20, 0);
        wall[6][4] = 1;
        run_pass(8'h03, 0, 0, 0, 0, 0, 0);
        check("t6_collide", collide, 4'b0011);
        clear_walls();
`endif

        for (int p = 0; p < 30; p++) begin
            clear_walls();
            for (int x = 1; x < 28; x++)
                for (int y = 1; y < 28; y++) wall[x][y] = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 1) == 1) begin
                    w = $urandom_range(0, 2);
                    load_actor(i, (w == 0) ? 1 : (w == 1) ? 27 : $urandom_range(1, 27),
                               $urandom_range(0, 1) ? 1 : $urandom_range(1, 27), $urandom_range(0, 3));
                end
            run_pass(8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3), $urandom_range(1, 27), $urandom_range(1, 27),
                     $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
